// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: D = A - B (mod 2^WIDTH), Bout = (A < B).
// One full-adder slice per clock, LSB first, computed as A + ~B + 1.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] D,
  output logic             Bout
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] nb_reg;
  logic [WIDTH-1:0] res_reg;
  logic             carry_reg;
  logic [CW-1:0]    count_reg;

  logic             sum_bit;
  logic             carry_next;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  // Single full-adder slice shared by every bit position.
  always_comb begin
    sum_bit    = a_reg[0] ^ nb_reg[0] ^ carry_reg;
    carry_next = (a_reg[0] & nb_reg[0]) | (a_reg[0] & carry_reg) | (nb_reg[0] & carry_reg);
    res_next   = {sum_bit, res_reg[WIDTH-1:1]};
    last_bit   = (count_reg == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      a_reg     <= '0;
      nb_reg    <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      count_reg <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      D         <= '0;
      Bout      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            // Carry-in of 1 turns A + ~B into two's-complement subtraction.
            a_reg     <= A;
            nb_reg    <= ~B;
            res_reg   <= '0;
            carry_reg <= 1'b1;
            count_reg <= '0;
            busy      <= 1'b1;
            state_reg <= SHIFT;
          end else begin
            state_reg <= IDLE;
          end
        end
        SHIFT: begin
          a_reg     <= a_reg >> 1;
          nb_reg    <= nb_reg >> 1;
          res_reg   <= res_next;
          carry_reg <= carry_next;
          count_reg <= count_reg + 1'b1;
          if (last_bit) begin
            // No carry out of the top slice means a borrow was needed.
            D         <= res_next;
            Bout      <= ~carry_next;
            busy      <= 1'b0;
            done      <= 1'b1;
            state_reg <= DONE;
          end
        end
        default: begin
          busy      <= 1'b0;
          done      <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule
